// File: rtl/alu_sub_sequencer.sv
// Round-robin sequencer sharing one iterative subtract-with-feedback datapath between two requesters.
// Optional feature: define ALU_SUB_SAT_EN to saturate the accumulator at 0 on underflow instead of wrapping.
module alu_sub_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic [CNT_W-1:0]     req0_cnt,
    input  logic [CNT_W-1:0]     req1_cnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_borrow,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             borrow_q, borrow_d;
    logic             last_q, last_d;

    logic [1:0]       grant_c;
    logic             sel_c;
    logic             under_c;
    logic [WIDTH-1:0] diff_c;
    logic [CNT_W-1:0] new_cnt_c;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_c = 2'b00;
        case (req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE) ? grant_c : 2'b00;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        borrow_d  = borrow_q;
        last_d    = last_q;
        sel_c     = req_ready[1];
        under_c   = (acc_q < b_q);
        diff_c    = acc_q - b_q;
        new_cnt_c = sel_c ? req1_cnt : req0_cnt;

        case (state_q)
            ST_IDLE: begin
                if ((req_valid & req_ready) != 2'b00) begin
                    acc_d    = sel_c ? req1_a : req0_a;
                    b_d      = sel_c ? req1_b : req0_b;
                    cnt_d    = new_cnt_c;
                    id_d     = sel_c;
                    borrow_d = 1'b0;
                    last_d   = sel_c;
                    state_d  = (new_cnt_c != CNT_W'(0)) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
`ifdef ALU_SUB_SAT_EN
                acc_d = under_c ? WIDTH'(0) : diff_c;
`else
                acc_d = diff_c;
`endif
                borrow_d = borrow_q | under_c;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Next grant is only evaluated once back in IDLE.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            borrow_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            borrow_q <= borrow_d;
            last_q   <= last_d;
        end
    end

    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_id     = id_q;
    assign rsp_result = {{WIDTH{1'b0}}, acc_q};
    assign rsp_borrow = borrow_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
